fmul_round_pack: RTL

Back-end stage of the single-precision multiplier. It consumes the raw 48-bit significand product, the biased exponent sum and the original operands, and produces a packed IEEE 754 result with exception flags.
- Work done: normalisation, round-to-nearest-even, overflow/underflow handling and special-operand handling (NaN, Inf, zero).
- Structure: two-stage valid/ready pipeline, so the multiplier can stall behind a slow writeback consumer.

---
 rtl/fmul_round_pack.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fmul_round_pack.sv
// fmul_round_pack: back end of the single-precision multiplier.
//   Stage 1 classifies the original operands and normalises the raw 48-bit
//   significand product into a 24-bit significand plus guard/sticky bits.
//   Stage 2 applies round-to-nearest-even, resolves special operands,
//   overflow and underflow, and registers the packed IEEE 754 result.
// Ports:
//   clk, resetn              clock, asynchronous active-high reset
//   in_valid/in_ready        upstream handshake
//   in_rs1, in_rs2           original operands (sign and classification)
//   in_exp                   signed biased exponent sum e1+e2-127
//   in_mant                  48-bit significand product, hidden bits included
//   out_valid/out_ready      downstream handshake
//   out                      packed result {sign, exp[7:0], frac[22:0]}
//   out_flags                {invalid, overflow, underflow, inexact}
module fmul_round_pack #(
  parameter int          EXPW      = 10,
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_rs1,
  input  logic [31:0]            in_rs2,
  input  logic signed [EXPW-1:0] in_exp,
  input  logic [47:0]            in_mant,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out,
  output logic [3:0]             out_flags
);

  localparam logic signed [EXPW-1:0] E_ZERO = '0;
  localparam logic signed [EXPW-1:0] E_ONE  = EXPW'(1);
  localparam logic signed [EXPW-1:0] E_MAX  = EXPW'(255);

  // ---------------- handshake ----------------
  logic s1_valid, s1_adv, s1_load;

  assign s1_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s1_adv;
  assign s1_load  = in_valid && in_ready;

  // ---------------- stage 1: classify + normalise ----------------
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;

  assign a_nan  = (in_rs1[30:23] == 8'hFF) && (in_rs1[22:0] != 23'd0);
  assign b_nan  = (in_rs2[30:23] == 8'hFF) && (in_rs2[22:0] != 23'd0);
  assign a_snan = a_nan && !in_rs1[22];
  assign b_snan = b_nan && !in_rs2[22];
  assign a_inf  = (in_rs1[30:23] == 8'hFF) && (in_rs1[22:0] == 23'd0);
  assign b_inf  = (in_rs2[30:23] == 8'hFF) && (in_rs2[22:0] == 23'd0);
  // Denormals flush to zero, so a zero exponent field is enough.
  assign a_zero = (in_rs1[30:23] == 8'h00);
  assign b_zero = (in_rs2[30:23] == 8'h00);

  logic                   n_sticky;
  logic [23:0]            n_sig;
  logic signed [EXPW-1:0] n_exp;
  logic                   n_guard;

  always_comb begin
    if (in_mant[47]) begin
      // Product in [2,4): shift right one, bit 0 joins the sticky.
      n_sig    = in_mant[47:24];
      n_guard  = in_mant[23];
      n_sticky = |in_mant[22:0];
      n_exp    = in_exp + E_ONE;
    end else begin
      n_sig    = in_mant[46:23];
      n_guard  = in_mant[22];
      n_sticky = |in_mant[21:0];
      n_exp    = in_exp;
    end
  end

  logic                   s1_sign, s1_nan, s1_invalid, s1_inf, s1_zero;
  logic [23:0]            s1_sig;
  logic signed [EXPW-1:0] s1_e;
  logic                   s1_guard, s1_sticky;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_nan     <= 1'b0;
      s1_invalid <= 1'b0;
      s1_inf     <= 1'b0;
      s1_zero    <= 1'b0;
      s1_sig     <= '0;
      s1_e       <= '0;
      s1_guard   <= 1'b0;
      s1_sticky  <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s1_load) begin
        s1_sign    <= in_rs1[31] ^ in_rs2[31];
        // Inf*zero is folded into the NaN class; it also raises invalid.
        s1_nan     <= a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
        s1_invalid <= a_snan || b_snan || (a_inf && b_zero) || (a_zero && b_inf);
        s1_inf     <= a_inf || b_inf;
        s1_zero    <= a_zero || b_zero;
        s1_sig     <= n_sig;
        s1_e       <= n_exp;
        s1_guard   <= n_guard;
        s1_sticky  <= n_sticky;
      end
    end
  end

  // ---------------- stage 2: round + pack ----------------
  logic                   rup;
  logic [24:0]            sig_rnd;
  logic signed [EXPW-1:0] e_fin;
  logic [31:0]            res;
  logic [3:0]             flg;

  assign rup     = s1_guard && (s1_sticky || s1_sig[0]);
  assign sig_rnd = {1'b0, s1_sig} + {24'd0, rup};
  // A carry out of 24 bits leaves sig_rnd[23:0] all zero: frac is 0.
  assign e_fin   = s1_e + (sig_rnd[24] ? E_ONE : E_ZERO);

  always_comb begin
    res = '0;
    flg = '0;
    if (s1_nan) begin
      res = CANON_NAN;
      flg = {s1_invalid, 3'b000};
    end else if (s1_inf) begin
      res = {s1_sign, 8'hFF, 23'd0};
    end else if (s1_zero) begin
      res = {s1_sign, 31'd0};
    end else if (s1_e <= E_ZERO) begin
      res = {s1_sign, 31'd0};
      flg = 4'b0011;
    end else if (e_fin >= E_MAX) begin
      res = {s1_sign, 8'hFF, 23'd0};
      flg = 4'b0101;
    end else begin
      res = {s1_sign, e_fin[7:0], sig_rnd[22:0]};
      flg = {3'b000, s1_guard | s1_sticky};
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_flags <= '0;
    end else begin
      if (s1_adv) begin
        out_valid <= 1'b1;
        out       <= res;
        out_flags <= flg;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
